// File: rtl/bus_pkg.sv
// Shared types for the 68030 bus-cycle terminator: FSM states, termination kinds,
// port-size codes and the DSACK encoding helper.
package bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_EXT,
    ST_ACK,
    ST_FAULT,
    ST_HOLD
  } bus_state_e;

  typedef enum logic [1:0] {
    TERM_NONE,
    TERM_DSACK,
    TERM_AVEC,
    TERM_VEC
  } term_kind_e;

  localparam logic [1:0] PORT_32  = 2'd0;
  localparam logic [1:0] PORT_8   = 2'd1;
  localparam logic [1:0] PORT_16  = 2'd2;
  localparam logic [1:0] PORT_EXT = 2'd3;

  // Returns {DSACK1_n, DSACK0_n} for a locally terminated port size.
  function automatic logic [1:0] dsack_pair(input logic [1:0] port);
    case (port)
      PORT_32: return 2'b00;
      PORT_8:  return 2'b10;
      PORT_16: return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Loadable down-counter with clear and enable; o_expire is high while enabled at zero.
module bus_watchdog #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_expire = i_en && (r_cnt == '0);

endmodule

// File: rtl/bus_cycle_terminator.sv
// Terminates 68030 async bus cycles (DSACK/AVEC/BERR) from one registered FSM.
// Define BUS_WATCHDOG_EN to include the bus-error watchdog and TIMEOUT_STB.
module bus_cycle_terminator
  import bus_pkg::*;
#(
  parameter int                          N_REGIONS   = 8,
  parameter int                          WS_W        = 4,
  parameter logic [N_REGIONS*WS_W-1:0]   REGION_WS   = '0,
  parameter logic [N_REGIONS*2-1:0]      REGION_PORT = '0,
  parameter int                          AVEC_WS     = 1,
  parameter int                          TIMEOUT     = 255,
  parameter int                          TO_W        = $clog2(TIMEOUT + 1)
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 AS_n,
  input  logic [N_REGIONS-1:0] SEL_n,
  input  logic [N_REGIONS-1:0] EXT_DSACK0_n,
  input  logic [N_REGIONS-1:0] EXT_DSACK1_n,
  input  logic                 IACK_n,
  input  logic                 IACK_VEC_n,
  input  logic                 VEC_DSACK0_n,
  output logic                 DSACK0_n,
  output logic                 DSACK1_n,
  output logic                 AVEC_n,
  output logic                 BERR_n,
  output logic                 BUSY,
  output logic                 TIMEOUT_STB,
  output bus_state_e           o_dbg_state
);

  localparam int IDX_W = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

  bus_state_e       r_state, w_state_d;
  term_kind_e       r_kind, w_kind_d;
  logic [IDX_W-1:0] r_idx, w_idx_d, w_sel_idx;
  logic [1:0]       r_port, w_port_d;
  logic [WS_W-1:0]  r_ws_cnt, w_cnt_d;
  logic [4:0]       w_sel_cnt;
  logic             r_dsack0_n, r_dsack1_n, r_avec_n, r_berr_n, r_to_stb;
  logic             w_dsack0_d, w_dsack1_d, w_avec_d, w_berr_d, w_to_stb_d;
  logic             w_expire;

  always_comb begin
    w_sel_cnt = '0;
    w_sel_idx = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      if (!SEL_n[i]) begin
        w_sel_cnt = w_sel_cnt + 5'd1;
        w_sel_idx = IDX_W'(i);
      end
    end
  end

`ifdef BUS_WATCHDOG_EN
  logic w_wd_en, w_wd_load;
  assign w_wd_en   = (r_state == ST_WAIT) || (r_state == ST_EXT);
  assign w_wd_load = (r_state == ST_IDLE) && !AS_n;

  // Loaded with TIMEOUT-1 so expiry lands exactly TIMEOUT clocks after cycle start.
  bus_watchdog #(.W(TO_W)) u_watchdog (
    .i_clk      (CLK),
    .i_rst_n    (RST_n),
    .i_clr      (!w_wd_en),
    .i_load     (w_wd_load),
    .i_load_val (TO_W'(TIMEOUT - 1)),
    .i_en       (w_wd_en),
    .o_expire   (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_kind_d   = r_kind;
    w_idx_d    = r_idx;
    w_port_d   = r_port;
    w_cnt_d    = r_ws_cnt;
    w_to_stb_d = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!AS_n) begin
          if (w_sel_cnt > 5'd1) begin
            w_state_d = ST_FAULT;
          end else if (!IACK_n && !IACK_VEC_n) begin
            w_state_d = ST_EXT;
            w_kind_d  = TERM_VEC;
          end else if (!IACK_n) begin
            w_state_d = ST_WAIT;
            w_kind_d  = TERM_AVEC;
            w_cnt_d   = WS_W'(AVEC_WS);
          end else if (w_sel_cnt == 5'd1) begin
            w_idx_d  = w_sel_idx;
            w_kind_d = TERM_DSACK;
            w_port_d = REGION_PORT[w_sel_idx*2 +: 2];
            if (w_port_d == PORT_EXT) begin
              w_state_d = ST_EXT;
            end else begin
              w_state_d = ST_WAIT;
              w_cnt_d   = REGION_WS[w_sel_idx*WS_W +: WS_W];
            end
          end else begin
            w_state_d = ST_WAIT;
            w_kind_d  = TERM_NONE;
            w_cnt_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        // A local terminator wins a tie with the watchdog.
        if (AS_n) begin
          w_state_d = ST_HOLD;
        end else if ((r_ws_cnt == '0) && (r_kind != TERM_NONE)) begin
          w_state_d = ST_ACK;
        end else if (w_expire) begin
          w_state_d  = ST_FAULT;
          w_to_stb_d = 1'b1;
        end else if (r_ws_cnt != '0) begin
          w_cnt_d = r_ws_cnt - 1'b1;
        end
      end
      ST_EXT: begin
        if (AS_n) begin
          w_state_d = ST_HOLD;
        end else if (w_expire) begin
          w_state_d  = ST_FAULT;
          w_to_stb_d = 1'b1;
        end
      end
      ST_ACK, ST_FAULT: begin
        if (AS_n) w_state_d = ST_HOLD;
      end
      ST_HOLD: w_state_d = ST_IDLE;
      default: w_state_d = ST_IDLE;
    endcase

    w_dsack1_d = 1'b1;
    w_dsack0_d = 1'b1;
    w_avec_d   = 1'b1;
    w_berr_d   = 1'b1;
    if (w_state_d == ST_ACK) begin
      if (w_kind_d == TERM_AVEC) w_avec_d = 1'b0;
      else {w_dsack1_d, w_dsack0_d} = dsack_pair(w_port_d);
    end
    if (w_state_d == ST_FAULT) w_berr_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state    <= ST_IDLE;
      r_kind     <= TERM_NONE;
      r_idx      <= '0;
      r_port     <= PORT_32;
      r_ws_cnt   <= '0;
      r_dsack0_n <= 1'b1;
      r_dsack1_n <= 1'b1;
      r_avec_n   <= 1'b1;
      r_berr_n   <= 1'b1;
      r_to_stb   <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_kind     <= w_kind_d;
      r_idx      <= w_idx_d;
      r_port     <= w_port_d;
      r_ws_cnt   <= w_cnt_d;
      r_dsack0_n <= w_dsack0_d;
      r_dsack1_n <= w_dsack1_d;
      r_avec_n   <= w_avec_d;
      r_berr_n   <= w_berr_d;
      r_to_stb   <= w_to_stb_d;
    end
  end

  // EXT forwards the acknowledging device's pins straight through.
  assign DSACK0_n    = (r_state == ST_EXT) ?
                       ((r_kind == TERM_VEC) ? VEC_DSACK0_n : EXT_DSACK0_n[r_idx]) : r_dsack0_n;
  assign DSACK1_n    = (r_state == ST_EXT) ?
                       ((r_kind == TERM_VEC) ? 1'b1 : EXT_DSACK1_n[r_idx]) : r_dsack1_n;
  assign AVEC_n      = r_avec_n;
  assign BERR_n      = r_berr_n;
  assign BUSY        = (r_state != ST_IDLE);
  assign TIMEOUT_STB = r_to_stb;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bus_cycle_terminator.sv
// Bench for bus_cycle_terminator: random region/IACK/EXT cycles against a table model.
module tb_bus_cycle_terminator;
  import bus_pkg::*;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic       AS_n = 1'b1;
  logic       IACK_n = 1'b1;
  logic       IACK_VEC_n = 1'b1;
  logic       VEC_DSACK0_n = 1'b1;
  logic [7:0] SEL_n = 8'hFF;
  logic [7:0] EXT_DSACK0_n = 8'hFF;
  logic [7:0] EXT_DSACK1_n = 8'hFF;
  logic       DSACK0_n, DSACK1_n, AVEC_n, BERR_n, BUSY, TIMEOUT_STB;
  bus_state_e dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  // Region table: wait states and port width in bytes (0 = externally acknowledged).
  int ws_tab[8]    = '{0, 5, 3, 1, 7, 2, 12, 4};
  int width_tab[8] = '{4, 2, 1, 0, 4, 1, 2, 0};
  int pool[6]      = '{0, 1, 2, 4, 5, 6};

  // {DSACK1_n, DSACK0_n, AVEC_n, BERR_n, BUSY, TIMEOUT_STB}
  logic [5:0] obs;
  assign obs = {DSACK1_n, DSACK0_n, AVEC_n, BERR_n, BUSY, TIMEOUT_STB};

  bus_cycle_terminator #(
    .N_REGIONS   (8),
    .WS_W        (4),
    .REGION_WS   (32'h4C27_1350),
    .REGION_PORT (16'hE4D8),
    .AVEC_WS     (1),
    .TIMEOUT     (16)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .AS_n         (AS_n),
    .SEL_n        (SEL_n),
    .EXT_DSACK0_n (EXT_DSACK0_n),
    .EXT_DSACK1_n (EXT_DSACK1_n),
    .IACK_n       (IACK_n),
    .IACK_VEC_n   (IACK_VEC_n),
    .VEC_DSACK0_n (VEC_DSACK0_n),
    .DSACK0_n     (DSACK0_n),
    .DSACK1_n     (DSACK1_n),
    .AVEC_n       (AVEC_n),
    .BERR_n       (BERR_n),
    .BUSY         (BUSY),
    .TIMEOUT_STB  (TIMEOUT_STB),
    .o_dbg_state  (dbg_state)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL global_time_limit checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [1:0] model_pins(input int width);
    case (width)
      4:       return 2'b00;
      2:       return 2'b01;
      1:       return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [7:0] one_low(input int idx);
    logic [7:0] v;
    v = 8'hFF;
    v[idx] = 1'b0;
    return v;
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if (obs !== 6'b111100) begin
      errors++; $display("FAIL reset_asserted obs=%b exp=%b", obs, 6'b111100);
    end
    RST_n = 1'b1;
    tick();
    checks++;
    if (obs !== 6'b111100) begin
      errors++; $display("FAIL reset_released obs=%b exp=%b", obs, 6'b111100);
    end
  endtask

  task automatic test_regions();
    for (int it = 0; it < 24; it++) begin
      int idx, hold, lat, first;
      logic [5:0] exp;
      logic [7:0] want;
      idx  = pool[$urandom_range(0, 5)];
      hold = $urandom_range(0, 3);
      lat  = ws_tab[idx] + 1;
      exp_q.push_back(8'(lat));
      SEL_n = one_low(idx);
      AS_n  = 1'b0;
      first = -1;
      for (int k = 0; k <= lat + hold; k++) begin
        tick();
        exp = {((k >= lat) ? model_pins(width_tab[idx]) : 2'b11), 4'b1110};
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL region%0d_k%0d obs=%b exp=%b", idx, k, obs, exp);
        end
        if (first < 0 && obs[5:4] != 2'b11) first = k;
        if (k == 0) SEL_n = one_low($urandom_range(0, 7));
      end
      want = exp_q.pop_front();
      checks++;
      if (8'(first) !== want) begin
        errors++; $display("FAIL region%0d_latency got=%0d exp=%0d", idx, first, want);
      end
      AS_n = 1'b1; SEL_n = 8'hFF;
      tick();
      checks++;
      if (obs !== 6'b111110) begin
        errors++; $display("FAIL region%0d_hold obs=%b exp=%b", idx, obs, 6'b111110);
      end
      tick();
      checks++;
      if (obs !== 6'b111100) begin
        errors++; $display("FAIL region%0d_idle obs=%b exp=%b", idx, obs, 6'b111100);
      end
    end
  endtask

  task automatic test_ext();
    for (int it = 0; it < 6; it++) begin
      int idx;
      logic [5:0] exp;
      idx = ($urandom_range(0, 1) == 1) ? 7 : 3;
      SEL_n = one_low(idx);
      AS_n  = 1'b0;
      tick();
      checks++;
      if (obs !== 6'b111110) begin
        errors++; $display("FAIL ext%0d_start obs=%b exp=%b", idx, obs, 6'b111110);
      end
      for (int k = 1; k <= 8; k++) begin
        tick();
        EXT_DSACK0_n = 8'($urandom);
        EXT_DSACK1_n = 8'($urandom);
        SEL_n = one_low($urandom_range(0, 7));
        #1;
        exp = {EXT_DSACK1_n[idx], EXT_DSACK0_n[idx], 4'b1110};
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL ext%0d_k%0d obs=%b exp=%b", idx, k, obs, exp);
        end
      end
      EXT_DSACK0_n = 8'hFF; EXT_DSACK1_n = 8'hFF;
      AS_n = 1'b1; SEL_n = 8'hFF;
      tick();
      checks++;
      if (obs !== 6'b111110) begin
        errors++; $display("FAIL ext%0d_hold obs=%b exp=%b", idx, obs, 6'b111110);
      end
      tick();
    end
  endtask

  task automatic test_iack_avec();
    for (int it = 0; it < 2; it++) begin
      logic [5:0] exp;
      IACK_n = 1'b0; IACK_VEC_n = 1'b1;
      SEL_n = (it == 0) ? 8'hFF : one_low($urandom_range(0, 7));
      AS_n = 1'b0;
      for (int k = 0; k <= 4; k++) begin
        tick();
        exp = {2'b11, ((k >= 2) ? 1'b0 : 1'b1), 3'b110};
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL avec_k%0d obs=%b exp=%b", k, obs, exp);
        end
      end
      AS_n = 1'b1; IACK_n = 1'b1; SEL_n = 8'hFF;
      tick();
      checks++;
      if (obs !== 6'b111110) begin
        errors++; $display("FAIL avec_hold obs=%b exp=%b", obs, 6'b111110);
      end
      tick();
    end
  endtask

  task automatic test_iack_vec(input int t);
    logic [5:0] exp;
    IACK_n = 1'b0; IACK_VEC_n = 1'b0; VEC_DSACK0_n = 1'b1;
    AS_n = 1'b0;
    for (int k = 0; k <= t + 2; k++) begin
      tick();
      if (k == t) VEC_DSACK0_n = 1'b0;
      #1;
      exp = {1'b1, ((k >= t) ? 1'b0 : 1'b1), 4'b1110};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL vec_t%0d_k%0d obs=%b exp=%b", t, k, obs, exp);
      end
    end
    AS_n = 1'b1; IACK_n = 1'b1; IACK_VEC_n = 1'b1; VEC_DSACK0_n = 1'b1;
    tick();
    checks++;
    if (obs !== 6'b111110) begin
      errors++; $display("FAIL vec_hold obs=%b exp=%b", obs, 6'b111110);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic [5:0] exp;
    SEL_n = 8'hFF;
    AS_n = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
`ifdef BUS_WATCHDOG_EN
      exp = {3'b111, ((k >= 16) ? 1'b0 : 1'b1), 1'b1, ((k == 16) ? 1'b1 : 1'b0)};
`else
      exp = 6'b111110;
`endif
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL timeout_k%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    AS_n = 1'b1;
    tick();
    checks++;
    if (obs !== 6'b111110) begin
      errors++; $display("FAIL timeout_hold obs=%b exp=%b", obs, 6'b111110);
    end
    tick();
    checks++;
    if (obs !== 6'b111100) begin
      errors++; $display("FAIL timeout_idle obs=%b exp=%b", obs, 6'b111100);
    end
  endtask

  task automatic test_conflict(input int a, input int b);
    SEL_n = one_low(a) & one_low(b);
    AS_n = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      tick();
      checks++;
      if (k == 0) begin
        if (obs[5:3] !== 3'b111) begin
          errors++; $display("FAIL conflict_k0 term=%b exp=%b", obs[5:3], 3'b111);
        end
      end else if (obs !== 6'b111010) begin
        errors++; $display("FAIL conflict_%0d_%0d_k%0d obs=%b exp=%b", a, b, k, obs, 6'b111010);
      end
    end
    AS_n = 1'b1; SEL_n = 8'hFF;
    tick();
    checks++;
    if (obs !== 6'b111110) begin
      errors++; $display("FAIL conflict_hold obs=%b exp=%b", obs, 6'b111110);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    SEL_n = one_low(4); AS_n = 1'b0;
    repeat (3) tick();
    #2 RST_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b111100) begin
      errors++; $display("FAIL reset_mid_wait obs=%b exp=%b", obs, 6'b111100);
    end
    AS_n = 1'b1; SEL_n = 8'hFF;
    #1 RST_n = 1'b1;
    tick();
    SEL_n = one_low(0); AS_n = 1'b0;
    tick();
    tick();
    checks++;
    if (obs !== 6'b001110) begin
      errors++; $display("FAIL reset_pre_ack obs=%b exp=%b", obs, 6'b001110);
    end
    #2 RST_n = 1'b0;
    #1;
    checks++;
    if (obs !== 6'b111100) begin
      errors++; $display("FAIL reset_mid_ack obs=%b exp=%b", obs, 6'b111100);
    end
    AS_n = 1'b1; SEL_n = 8'hFF;
    #1 RST_n = 1'b1;
    tick();
    SEL_n = one_low(2); AS_n = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      tick();
      exp = {((k >= 4) ? 2'b10 : 2'b11), 4'b1110};
      checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL post_reset_k%0d obs=%b exp=%b", k, obs, exp);
      end
    end
    AS_n = 1'b1; SEL_n = 8'hFF;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    for (int it = 0; it < 4; it++) begin
      int i1, i2, lat2;
      logic [5:0] exp;
      i1 = pool[$urandom_range(0, 5)];
      i2 = pool[$urandom_range(0, 5)];
      lat2 = ws_tab[i2] + 1;
      SEL_n = one_low(i1); AS_n = 1'b0;
      repeat (ws_tab[i1] + 2) tick();
      AS_n = 1'b1;
      tick();
      AS_n = 1'b0; SEL_n = one_low(i2);
      tick();
      checks++;
      if (obs !== 6'b111100) begin
        errors++; $display("FAIL b2b_not_accepted obs=%b exp=%b", obs, 6'b111100);
      end
      for (int k = 0; k <= lat2; k++) begin
        tick();
        exp = {((k >= lat2) ? model_pins(width_tab[i2]) : 2'b11), 4'b1110};
        checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL b2b_region%0d_k%0d obs=%b exp=%b", i2, k, obs, exp);
        end
      end
      AS_n = 1'b1; SEL_n = 8'hFF;
      tick();
      tick();
    end
  endtask

  initial begin
    int a, b;
    test_reset();
    test_regions();
    test_ext();
    test_iack_avec();
    test_iack_vec(5);
    test_iack_vec($urandom_range(0, 10));
    test_timeout();
    test_conflict(1, 3);
    a = $urandom_range(0, 7);
    b = (a + $urandom_range(1, 7)) % 8;
    test_conflict(a, b);
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
